// File: rtl/ex_stage_mul_pkg.sv
// Shared encodings for the EX stage: ALUOp/funct constants, ALU operation,
// multiplier FSM state and forwarding-select enums, plus the forwarding priority helper.
package ex_stage_mul_pkg;

    localparam logic [1:0] ALUOP_ADD = 2'b00;
    localparam logic [1:0] ALUOP_SUB = 2'b01;
    localparam logic [1:0] ALUOP_R   = 2'b10;
    localparam logic [1:0] ALUOP_I   = 2'b11;

    localparam logic [6:0] F7_BASE   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    localparam logic [2:0] F3_ADD = 3'b000;
    localparam logic [2:0] F3_SLL = 3'b001;
    localparam logic [2:0] F3_XOR = 3'b100;
    localparam logic [2:0] F3_SR  = 3'b101;
    localparam logic [2:0] F3_AND = 3'b111;

    typedef enum logic [2:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_AND,
        ALU_XOR,
        ALU_SLL,
        ALU_SRA,
        ALU_MUL
    } alu_op_e;

    typedef enum logic [1:0] {
        MUL_IDLE,
        MUL_BUSY,
        MUL_DONE
    } mul_state_e;

    typedef enum logic [1:0] {
        FWD_NONE,
        FWD_MEM,
        FWD_WB
    } fwd_sel_e;

    // MEM is the younger producer, so it wins over WB; x0 is never forwarded.
    function automatic fwd_sel_e fwd_select(
        input logic [4:0] rs,
        input logic [4:0] mem_rd,
        input logic       mem_we,
        input logic [4:0] wb_rd,
        input logic       wb_we
    );
        if (mem_we && (mem_rd != 5'd0) && (mem_rd == rs))
            return FWD_MEM;
        else if (wb_we && (wb_rd != 5'd0) && (wb_rd == rs))
            return FWD_WB;
        else
            return FWD_NONE;
    endfunction

endpackage

// File: rtl/ex_stage_mul_mul.sv
// Iterative shift-add multiplier: IDLE latches operands, BUSY retires MUL_BPC bits
// per cycle for 32/MUL_BPC cycles, DONE presents the low 32 product bits for one cycle.
module ex_stage_mul_mul
    import ex_stage_mul_pkg::*;
#(
    parameter int MUL_BPC = 1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        i_start,
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    output logic        o_done,
    output logic [31:0] o_product
);

    localparam int ITER = 32 / MUL_BPC;
    localparam int CW   = (ITER > 1) ? $clog2(ITER) : 1;

    mul_state_e   r_state;
    logic [CW-1:0] r_cnt;
    logic [31:0]  r_acc;
    logic [31:0]  r_mcand;
    logic [31:0]  r_mplier;
    logic [31:0]  w_pp;

    always_comb begin
        w_pp = '0;
        for (int j = 0; j < MUL_BPC; j++) begin
            if (r_mplier[j])
                w_pp = w_pp + (r_mcand << j);
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state  <= MUL_IDLE;
            r_cnt    <= '0;
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
        end else begin
            case (r_state)
                MUL_IDLE: begin
                    if (i_start) begin
                        r_mcand  <= i_a;
                        r_mplier <= i_b;
                        r_acc    <= '0;
                        r_cnt    <= '0;
                        r_state  <= MUL_BUSY;
                    end
                end
                MUL_BUSY: begin
                    r_acc    <= r_acc + w_pp;
                    r_mcand  <= r_mcand << MUL_BPC;
                    r_mplier <= r_mplier >> MUL_BPC;
                    r_cnt    <= r_cnt + 1'b1;
                    if (r_cnt == CW'(ITER - 1))
                        r_state <= MUL_DONE;
                end
                default: r_state <= MUL_IDLE;
            endcase
        end
    end

    assign o_done    = (r_state == MUL_DONE);
    assign o_product = r_acc;

endmodule

// File: rtl/ex_stage_mul.sv
// EX stage: operand forwarding, ALU decode/execute, iterative MUL with front-end stall,
// and the EX/MEM register (1-edge latency for ALU ops, bubbles while a MUL stalls).
module ex_stage_mul
    import ex_stage_mul_pkg::*;
#(
    parameter int MUL_BPC = 1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] A_i,
    input  logic [31:0] B_i,
    input  logic [31:0] imme_i,
    input  logic [31:0] IR_i,
    input  logic [4:0]  RD_i,
    input  logic [4:0]  Rs1_i,
    input  logic [4:0]  Rs2_i,
    input  logic        RegWrite_i,
    input  logic        MemtoReg_i,
    input  logic        MemRead_i,
    input  logic        MemWrite_i,
    input  logic        ALUSrc_i,
    input  logic [1:0]  ALUOp_i,
    input  logic [4:0]  MemRD_i,
    input  logic        MemRegWrite_i,
    input  logic [31:0] MemFwd_i,
    input  logic [4:0]  WbRD_i,
    input  logic        WbRegWrite_i,
    input  logic [31:0] WbData_i,
    output logic        stall_o,
    output logic [31:0] ALUResult_o,
    output logic [31:0] MemData_o,
    output logic [4:0]  RD_o,
    output logic        RegWrite_o,
    output logic        MemtoReg_o,
    output logic        MemRead_o,
    output logic        MemWrite_o
);

    logic [6:0]  w_funct7;
    logic [2:0]  w_funct3;
    fwd_sel_e    w_sel_a;
    fwd_sel_e    w_sel_b;
    logic [31:0] w_op_a;
    logic [31:0] w_fwd_b;
    logic [31:0] w_op_b;
    alu_op_e     w_alu_op;
    logic [31:0] w_alu_res;
    logic        w_mul_in_ex;
    logic        w_mul_done;
    logic [31:0] w_product;
    logic        w_unused;

    logic [31:0] r_alu_result;
    logic [31:0] r_mem_data;
    logic [4:0]  r_rd;
    logic        r_reg_write;
    logic        r_mem_to_reg;
    logic        r_mem_read;
    logic        r_mem_write;

    assign w_funct7 = IR_i[31:25];
    assign w_funct3 = IR_i[14:12];
    assign w_unused = ^{IR_i[24:15], IR_i[11:0]};

    assign w_sel_a = fwd_select(Rs1_i, MemRD_i, MemRegWrite_i, WbRD_i, WbRegWrite_i);
    assign w_sel_b = fwd_select(Rs2_i, MemRD_i, MemRegWrite_i, WbRD_i, WbRegWrite_i);

    always_comb begin
        case (w_sel_a)
            FWD_MEM: w_op_a = MemFwd_i;
            FWD_WB:  w_op_a = WbData_i;
            default: w_op_a = A_i;
        endcase
        case (w_sel_b)
            FWD_MEM: w_fwd_b = MemFwd_i;
            FWD_WB:  w_fwd_b = WbData_i;
            default: w_fwd_b = B_i;
        endcase
    end

    assign w_op_b = ALUSrc_i ? imme_i : w_fwd_b;

    always_comb begin
        w_alu_op = ALU_ADD;
        case (ALUOp_i)
            ALUOP_SUB: w_alu_op = ALU_SUB;
            ALUOP_R: begin
                if (w_funct7 == F7_ALT && w_funct3 == F3_ADD)          w_alu_op = ALU_SUB;
                else if (w_funct7 == F7_BASE && w_funct3 == F3_AND)    w_alu_op = ALU_AND;
                else if (w_funct7 == F7_BASE && w_funct3 == F3_XOR)    w_alu_op = ALU_XOR;
                else if (w_funct7 == F7_BASE && w_funct3 == F3_SLL)    w_alu_op = ALU_SLL;
                else if (w_funct7 == F7_MULDIV && w_funct3 == F3_ADD)  w_alu_op = ALU_MUL;
            end
            ALUOP_I: begin
                if (w_funct3 == F3_SR && w_funct7 == F7_ALT)           w_alu_op = ALU_SRA;
            end
            default: w_alu_op = ALU_ADD;
        endcase
    end

    always_comb begin
        case (w_alu_op)
            ALU_SUB: w_alu_res = w_op_a - w_op_b;
            ALU_AND: w_alu_res = w_op_a & w_op_b;
            ALU_XOR: w_alu_res = w_op_a ^ w_op_b;
            ALU_SLL: w_alu_res = w_op_a << w_op_b[4:0];
            ALU_SRA: w_alu_res = $unsigned($signed(w_op_a) >>> imme_i[4:0]);
            default: w_alu_res = w_op_a + w_op_b;
        endcase
    end

    assign w_mul_in_ex = (w_alu_op == ALU_MUL);

    ex_stage_mul_mul #(
        .MUL_BPC (MUL_BPC)
    ) u_mul (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .i_start   (w_mul_in_ex),
        .i_a       (w_op_a),
        .i_b       (w_op_b),
        .o_done    (w_mul_done),
        .o_product (w_product)
    );

    assign stall_o = w_mul_in_ex && !w_mul_done;

    // A stalled MUL must not leak a partial result downstream, so EX/MEM takes a bubble.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_alu_result <= '0;
            r_mem_data   <= '0;
            r_rd         <= '0;
            r_reg_write  <= 1'b0;
            r_mem_to_reg <= 1'b0;
            r_mem_read   <= 1'b0;
            r_mem_write  <= 1'b0;
        end else if (stall_o) begin
            r_alu_result <= '0;
            r_mem_data   <= '0;
            r_rd         <= '0;
            r_reg_write  <= 1'b0;
            r_mem_to_reg <= 1'b0;
            r_mem_read   <= 1'b0;
            r_mem_write  <= 1'b0;
        end else begin
            r_alu_result <= w_mul_in_ex ? w_product : w_alu_res;
            r_mem_data   <= w_fwd_b;
            r_rd         <= RD_i;
            r_reg_write  <= RegWrite_i;
            r_mem_to_reg <= MemtoReg_i;
            r_mem_read   <= MemRead_i;
            r_mem_write  <= MemWrite_i;
        end
    end

    assign ALUResult_o = r_alu_result;
    assign MemData_o   = r_mem_data;
    assign RD_o        = r_rd;
    assign RegWrite_o  = r_reg_write;
    assign MemtoReg_o  = r_mem_to_reg;
    assign MemRead_o   = r_mem_read;
    assign MemWrite_o  = r_mem_write;

endmodule

// File: tb/tb_ex_stage_mul.sv
// Directed bench for ex_stage_mul: vector table for single-cycle ops plus
// hand-written multiply, back-to-back, dependent-op and reset-abort sequences.
module tb_ex_stage_mul;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    logic [31:0] A_i = '0, B_i = '0, imme_i = '0, IR_i = '0;
    logic [4:0]  RD_i = '0, Rs1_i = '0, Rs2_i = '0;
    logic        RegWrite_i = 1'b0, MemtoReg_i = 1'b0, MemRead_i = 1'b0, MemWrite_i = 1'b0;
    logic        ALUSrc_i = 1'b0;
    logic [1:0]  ALUOp_i = '0;
    logic [4:0]  MemRD_i = '0, WbRD_i = '0;
    logic        MemRegWrite_i = 1'b0, WbRegWrite_i = 1'b0;
    logic [31:0] MemFwd_i = '0, WbData_i = '0;
    logic        stall_o;
    logic [31:0] ALUResult_o, MemData_o;
    logic [4:0]  RD_o;
    logic        RegWrite_o, MemtoReg_o, MemRead_o, MemWrite_o;

    int total = 0;
    int bad   = 0;

    always #5 clk_i = ~clk_i;

    ex_stage_mul #(.MUL_BPC(1)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .A_i(A_i), .B_i(B_i), .imme_i(imme_i), .IR_i(IR_i),
        .RD_i(RD_i), .Rs1_i(Rs1_i), .Rs2_i(Rs2_i),
        .RegWrite_i(RegWrite_i), .MemtoReg_i(MemtoReg_i), .MemRead_i(MemRead_i),
        .MemWrite_i(MemWrite_i), .ALUSrc_i(ALUSrc_i), .ALUOp_i(ALUOp_i),
        .MemRD_i(MemRD_i), .MemRegWrite_i(MemRegWrite_i), .MemFwd_i(MemFwd_i),
        .WbRD_i(WbRD_i), .WbRegWrite_i(WbRegWrite_i), .WbData_i(WbData_i),
        .stall_o(stall_o), .ALUResult_o(ALUResult_o), .MemData_o(MemData_o),
        .RD_o(RD_o), .RegWrite_o(RegWrite_o), .MemtoReg_o(MemtoReg_o),
        .MemRead_o(MemRead_o), .MemWrite_o(MemWrite_o)
    );

    typedef struct {
        logic [31:0] a, b, imm, ir;
        logic [4:0]  rs1, rs2, rd;
        logic        alusrc;
        logic [1:0]  aluop;
        logic [4:0]  memrd;
        logic        memrw;
        logic [31:0] memfwd;
        logic [4:0]  wbrd;
        logic        wbrw;
        logic [31:0] wbdata;
        logic [3:0]  ctrl;
        logic [31:0] exp_res, exp_md;
    } vec_t;

    vec_t vecs[13];

    function automatic logic [31:0] mkir(input logic [6:0] f7, input logic [2:0] f3);
        return {f7, 10'd0, f3, 5'd0, 7'h33};
    endfunction

    function automatic vec_t mk(
        input logic [31:0] a, b, imm, ir,
        input logic [4:0] rs1, rs2, rd,
        input logic alusrc, input logic [1:0] aluop,
        input logic [4:0] memrd, input logic memrw, input logic [31:0] memfwd,
        input logic [4:0] wbrd, input logic wbrw, input logic [31:0] wbdata,
        input logic [3:0] ctrl, input logic [31:0] er, input logic [31:0] em
    );
        vec_t v;
        v.a = a; v.b = b; v.imm = imm; v.ir = ir;
        v.rs1 = rs1; v.rs2 = rs2; v.rd = rd;
        v.alusrc = alusrc; v.aluop = aluop;
        v.memrd = memrd; v.memrw = memrw; v.memfwd = memfwd;
        v.wbrd = wbrd; v.wbrw = wbrw; v.wbdata = wbdata;
        v.ctrl = ctrl; v.exp_res = er; v.exp_md = em;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        A_i = v.a; B_i = v.b; imme_i = v.imm; IR_i = v.ir;
        Rs1_i = v.rs1; Rs2_i = v.rs2; RD_i = v.rd;
        ALUSrc_i = v.alusrc; ALUOp_i = v.aluop;
        MemRD_i = v.memrd; MemRegWrite_i = v.memrw; MemFwd_i = v.memfwd;
        WbRD_i = v.wbrd; WbRegWrite_i = v.wbrw; WbData_i = v.wbdata;
        {RegWrite_i, MemtoReg_i, MemRead_i, MemWrite_i} = v.ctrl;
    endtask

    task automatic apply(input string name, input vec_t v);
        @(negedge clk_i);
        drive(v);
        #1;
        chk({name, "_stall"}, {31'd0, stall_o}, 32'd0);
        @(posedge clk_i);
        #1;
        chk({name, "_res"}, ALUResult_o, v.exp_res);
        chk({name, "_memdata"}, MemData_o, v.exp_md);
        chk({name, "_rd"}, {27'd0, RD_o}, {27'd0, v.rd});
        chk({name, "_ctrl"}, {28'd0, RegWrite_o, MemtoReg_o, MemRead_o, MemWrite_o},
            {28'd0, v.ctrl});
    endtask

    // Issues one mul and follows it until stall drops and the product is latched.
    task automatic run_mul(input string name, input logic [31:0] a, input logic [31:0] b,
                           input logic [4:0] rd, input bit toggle, input logic [31:0] exp);
        int  n;
        bit  bub_ok;
        bit  done;
        n = 0; bub_ok = 1'b1; done = 1'b0;
        @(negedge clk_i);
        drive(mk(a, b, 32'd0, mkir(7'b0000001, 3'b000), 5'd10, 5'd11, rd, 1'b0, 2'b10,
                 5'd0, 1'b0, 32'd0, 5'd0, 1'b0, 32'd0, 4'b1000, 32'd0, 32'd0));
        for (int c = 0; c < 100 && !done; c++) begin
            #1;
            if (stall_o) begin
                n++;
                @(posedge clk_i);
                #1;
                if (RegWrite_o || ALUResult_o != 0 || RD_o != 0 || MemData_o != 0)
                    bub_ok = 1'b0;
                if (toggle) begin
                    MemRegWrite_i = c[0]; MemRD_i = 5'd10; MemFwd_i = 32'(c) + 32'h100;
                    WbRegWrite_i = 1'b1; WbRD_i = 5'd11; WbData_i = ~32'(c);
                end
                @(negedge clk_i);
            end else begin
                done = 1'b1;
                @(posedge clk_i);
                #1;
            end
        end
        chk({name, "_completed"}, {31'd0, done}, 32'd1);
        chk({name, "_stall_cycles"}, 32'(n), 32'd33);
        chk({name, "_bubbles"}, {31'd0, bub_ok}, 32'd1);
        chk({name, "_product"}, ALUResult_o, exp);
        chk({name, "_regwrite"}, {31'd0, RegWrite_o}, 32'd1);
        chk({name, "_rd"}, {27'd0, RD_o}, {27'd0, rd});
        MemRegWrite_i = 1'b0; WbRegWrite_i = 1'b0; MemRD_i = '0; WbRD_i = '0;
    endtask

    initial begin
        bit clean;
        //             a             b             imm        ir                          rs1   rs2   rd    src  op     memrd mw  memfwd      wbrd  ww  wbdata       ctrl     res            memdata
        vecs[0]  = mk(32'd100,      32'd200,      32'd0,     mkir(7'b0000000, 3'b000), 5'd5, 5'd6, 5'd1, 1'b0, 2'b10, 5'd5, 1'b1, 32'd10,     5'd6, 1'b1, 32'd3,      4'b1000, 32'd13,        32'd3);
        vecs[1]  = mk(32'd50,       32'h55,       32'd1,     mkir(7'b0000000, 3'b000), 5'd5, 5'd0, 5'd2, 1'b1, 2'b11, 5'd5, 1'b1, 32'd7,      5'd5, 1'b1, 32'd9,      4'b1000, 32'd8,         32'h55);
        vecs[2]  = mk(32'h11,       32'h22,       32'd0,     32'd0,                    5'd0, 5'd7, 5'd3, 1'b0, 2'b00, 5'd0, 1'b1, 32'h1234,   5'd0, 1'b1, 32'h5678,   4'b0001, 32'h33,        32'h22);
        vecs[3]  = mk(32'h80000000, 32'd0,        32'd4,     mkir(7'b0100000, 3'b101), 5'd8, 5'd9, 5'd4, 1'b1, 2'b11, 5'd0, 1'b0, 32'd0,      5'd0, 1'b0, 32'd0,      4'b1000, 32'hF8000000,  32'd0);
        vecs[4]  = mk(32'd1,        32'd33,       32'd0,     mkir(7'b0000000, 3'b001), 5'd8, 5'd9, 5'd5, 1'b0, 2'b10, 5'd0, 1'b0, 32'd0,      5'd0, 1'b0, 32'd0,      4'b1000, 32'd2,         32'd33);
        vecs[5]  = mk(32'd0,        32'd1,        32'd0,     32'd0,                    5'd8, 5'd9, 5'd6, 1'b0, 2'b01, 5'd0, 1'b0, 32'd0,      5'd0, 1'b0, 32'd0,      4'b1000, 32'hFFFFFFFF,  32'd1);
        vecs[6]  = mk(32'hF0F01234, 32'h0FF0FF00, 32'd0,     mkir(7'b0000000, 3'b111), 5'd8, 5'd9, 5'd7, 1'b0, 2'b10, 5'd0, 1'b0, 32'd0,      5'd0, 1'b0, 32'd0,      4'b1000, 32'h00F01200,  32'h0FF0FF00);
        vecs[7]  = mk(32'hFFFF0000, 32'h0F0F0F0F, 32'd0,     mkir(7'b0000000, 3'b100), 5'd8, 5'd9, 5'd8, 1'b0, 2'b10, 5'd0, 1'b0, 32'd0,      5'd0, 1'b0, 32'd0,      4'b1000, 32'hF0F00F0F,  32'h0F0F0F0F);
        vecs[8]  = mk(32'd10,       32'd3,        32'd0,     mkir(7'b0100000, 3'b000), 5'd8, 5'd9, 5'd9, 1'b0, 2'b10, 5'd0, 1'b0, 32'd0,      5'd0, 1'b0, 32'd0,      4'b1000, 32'd7,         32'd3);
        vecs[9]  = mk(32'd5,        32'd3,        32'd0,     mkir(7'b0000000, 3'b110), 5'd8, 5'd9, 5'd10,1'b0, 2'b10, 5'd0, 1'b0, 32'd0,      5'd0, 1'b0, 32'd0,      4'b1000, 32'd8,         32'd3);
        vecs[10] = mk(32'd1,        32'hDEAD,     32'd0,     mkir(7'b0000000, 3'b000), 5'd8, 5'd9, 5'd11,1'b0, 2'b10, 5'd0, 1'b0, 32'd0,      5'd9, 1'b1, 32'h100,    4'b1110, 32'h101,       32'h100);
        vecs[11] = mk(32'h7FFFFFF0, 32'd0,        32'h24,    mkir(7'b0100000, 3'b101), 5'd8, 5'd9, 5'd12,1'b1, 2'b11, 5'd0, 1'b0, 32'd0,      5'd0, 1'b0, 32'd0,      4'b1000, 32'h07FFFFFF,  32'd0);
        vecs[12] = mk(32'h10,       32'd0,        32'h20,    mkir(7'b0000000, 3'b101), 5'd8, 5'd9, 5'd13,1'b1, 2'b11, 5'd0, 1'b0, 32'd0,      5'd0, 1'b0, 32'd0,      4'b1000, 32'h30,        32'd0);

        // Reset state
        #2;
        chk("reset_result", ALUResult_o, 32'd0);
        chk("reset_ctrl", {23'd0, RD_o, RegWrite_o, MemtoReg_o, MemRead_o, MemWrite_o}, 32'd0);
        chk("reset_stall", {31'd0, stall_o}, 32'd0);
        #20;
        rst_i = 1'b1;

        foreach (vecs[i]) apply($sformatf("vec%0d", i), vecs[i]);

        run_mul("mul_m1x3", 32'hFFFFFFFF, 32'd3, 5'd12, 1'b1, 32'hFFFFFFFD);

        run_mul("mul_6x7", 32'd6, 32'd7, 5'd3, 1'b0, 32'd42);
        run_mul("mul_2x21", 32'd2, 32'd21, 5'd4, 1'b0, 32'd42);
        apply("dep_add", mk(32'd0, 32'd0, 32'd0, mkir(7'b0000000, 3'b000), 5'd4, 5'd3, 5'd5,
                            1'b0, 2'b10, 5'd4, 1'b1, 32'd42, 5'd3, 1'b1, 32'd42,
                            4'b1000, 32'd84, 32'd42));

        // Reset asserted in the middle of BUSY
        @(negedge clk_i);
        drive(mk(32'd9, 32'd9, 32'd0, mkir(7'b0000001, 3'b000), 5'd10, 5'd11, 5'd14, 1'b0, 2'b10,
                 5'd0, 1'b0, 32'd0, 5'd0, 1'b0, 32'd0, 4'b1000, 32'd0, 32'd0));
        repeat (11) @(posedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b0;
        drive(mk(32'd0, 32'd0, 32'd0, 32'd0, 5'd0, 5'd0, 5'd0, 1'b0, 2'b00,
                 5'd0, 1'b0, 32'd0, 5'd0, 1'b0, 32'd0, 4'b0000, 32'd0, 32'd0));
        #1;
        chk("abort_result", ALUResult_o, 32'd0);
        chk("abort_ctrl", {23'd0, RD_o, RegWrite_o, MemtoReg_o, MemRead_o, MemWrite_o}, 32'd0);
        chk("abort_stall", {31'd0, stall_o}, 32'd0);
        @(negedge clk_i);
        rst_i = 1'b1;
        clean = 1'b1;
        repeat (3) begin
            @(posedge clk_i);
            #1;
            if (RegWrite_o || ALUResult_o != 0 || RD_o != 0 || stall_o) clean = 1'b0;
        end
        chk("abort_never_written", {31'd0, clean}, 32'd1);
        run_mul("mul_after_reset", 32'd5, 32'd5, 5'd7, 1'b0, 32'd25);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
